// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU/shifter: opcode and FSM state enums.
// Optional macro SEQ_ALU_ARITH_SHIFT_EN turns op 110 into an arithmetic right shift.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_OR   = 3'b000,
        OP_AND  = 3'b001,
        OP_ADD  = 3'b010,
        OP_LESS = 3'b011,
        OP_SLL  = 3'b100,
        OP_SRL  = 3'b101,
        OP_SRA  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Ops that take the iterative shift path; SRA only when sign-fill is built in.
    function automatic logic is_shift_op(input op_e op);
`ifdef SEQ_ALU_ARITH_SHIFT_EN
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`else
        return (op == OP_SLL) || (op == OP_SRL);
`endif
    endfunction

endpackage

// File: rtl/seq_alu_core.sv
// Single-cycle OR/AND/ADD/LESS datapath with signed-overflow flag.
// Any other opcode yields result 0 and overflow 0.
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              i_op,
    input  logic             i_invert_a,
    input  logic             i_invert_b,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;

    assign w_a   = i_invert_a ? ~i_src1 : i_src1;
    assign w_b   = i_invert_b ? ~i_src2 : i_src2;
    // invertB doubles as carry-in so that ADD with invertB computes A - B.
    assign w_sum = w_a + w_b + {{(WIDTH-1){1'b0}}, i_invert_b};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_op)
            OP_OR:   o_result = w_a | w_b;
            OP_AND:  o_result = w_a & w_b;
            OP_ADD: begin
                o_result   = w_sum;
                o_overflow = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_LESS: o_result = {{(WIDTH-1){1'b0}}, ($signed(i_src1) < $signed(i_src2))};
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_alu_shifter.sv
// Handshaked ALU/shifter: ALU ops finish in one cycle, shifts iterate SHIFT_STEP bits per cycle.
// Define SEQ_ALU_ARITH_SHIFT_EN to enable op 110 (SRA); otherwise it behaves as reserved.
module seq_alu_shifter
    import seq_alu_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int SHIFT_STEP = 1,
    localparam int SHAMT_W    = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic               invertA,
    input  logic               invertB,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow
);

    // One extra bit so a step equal to WIDTH is representable.
    localparam logic [SHAMT_W:0] STEP = (SHAMT_W+1)'(SHIFT_STEP);

    state_e             r_state;
    state_e             w_state_next;
    op_e                r_op;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W:0]   r_rem;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_overflow;

    op_e                w_op;
    logic               w_accept;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_alu_overflow;
    logic [SHAMT_W:0]   w_step;
    logic [SHAMT_W:0]   w_rem_next;
    logic [WIDTH-1:0]   w_shifted;

    assign w_op       = op_e'(op);
    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_is_shift = is_shift_op(w_op);

    seq_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op       (w_op),
        .i_invert_a (invertA),
        .i_invert_b (invertB),
        .i_src1     (src1),
        .i_src2     (src2),
        .o_result   (w_alu_result),
        .o_overflow (w_alu_overflow)
    );

    // Each SHIFT cycle moves min(STEP, remaining) bits.
    assign w_step     = (r_rem < STEP) ? r_rem : STEP;
    assign w_rem_next = r_rem - w_step;

    always_comb begin
        w_shifted = r_work;
        case (r_op)
            OP_SLL: w_shifted = r_work << w_step;
            OP_SRL: w_shifted = r_work >> w_step;
`ifdef SEQ_ALU_ARITH_SHIFT_EN
            OP_SRA: w_shifted = WIDTH'($signed(r_work) >>> w_step);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_is_shift ? SHIFT : DONE;
            SHIFT:   if (w_rem_next == '0) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the working registers are reset too, so nothing from an aborted shift survives.
            r_op       <= OP_OR;
            r_work     <= '0;
            r_rem      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op <= w_op;
                        if (w_is_shift) begin
                            r_work <= src2;
                            r_rem  <= {1'b0, shamt};
                        end else begin
                            r_result   <= w_alu_result;
                            r_zero     <= (w_alu_result == '0);
                            r_overflow <= w_alu_overflow;
                        end
                    end
                end
                SHIFT: begin
                    r_work <= w_shifted;
                    r_rem  <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_result   <= w_shifted;
                        r_zero     <= (w_shifted == '0);
                        r_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_alu_shifter.sv
// Directed, table-driven bench for seq_alu_shifter; a second instance with SHIFT_STEP=4
// is driven in parallel to check step-dependent shift latency.
module tb_seq_alu_shifter;
    import seq_alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready, in_ready4;
    logic [2:0]  op;
    logic        invertA, invertB;
    logic [31:0] src1, src2;
    logic [4:0]  shamt;
    logic        out_valid, out_valid4;
    logic        out_ready;
    logic [31:0] result, result4;
    logic        zero, zero4;
    logic        overflow, overflow4;

    int n_tests = 0;
    int n_fail  = 0;

    seq_alu_shifter #(.WIDTH(32), .SHIFT_STEP(1)) u_dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .invertA(invertA), .invertB(invertB), .src1(src1), .src2(src2), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .overflow(overflow)
    );

    seq_alu_shifter #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready4), .op(op),
        .invertA(invertA), .invertB(invertB), .src1(src1), .src2(src2), .shamt(shamt),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4), .zero(zero4),
        .overflow(overflow4)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic        ia;
        logic        ib;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  sh;
        logic [31:0] r;
        logic        z;
        logic        v;
        int          lat;
        int          lat4;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic ia, input logic ib,
                        input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] sh);
        int n;
        op = o; invertA = ia; invertB = ib; src1 = s1; src2 = s2; shamt = sh;
        in_valid = 1'b1;
        n = 0;
        while (!(in_ready && in_ready4) && n < 100) begin
            tick();
            n++;
        end
        if (!(in_ready && in_ready4)) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        tick();
        // Scramble inputs after the accept edge: the unit must use its captured copy.
        in_valid = 1'b0;
        op       = 3'($urandom);
        invertA  = 1'($urandom);
        invertB  = 1'($urandom);
        src1     = $urandom;
        src2     = $urandom;
        shamt    = 5'($urandom);
    endtask

    // Latency counts the accept edge as cycle 1.
    task automatic wait_valid(output int lat, output int lat4);
        lat  = 1;
        lat4 = out_valid4 ? 1 : 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
            if (out_valid4 && lat4 == 0) lat4 = lat;
        end
    endtask

    initial begin
        int lat, lat4, seen;

        //            op       ia ib src1          src2          sh  result        z  v  lat lat4
        vecs.push_back('{OP_ADD,  0, 0, 32'h7FFFFFFF, 32'h00000001, 0,  32'h80000000, 0, 1, 1,  1});
        vecs.push_back('{OP_ADD,  0, 1, 32'h00000005, 32'h00000005, 0,  32'h00000000, 1, 0, 1,  1});
        vecs.push_back('{OP_LESS, 0, 0, 32'hFFFFFFFF, 32'h00000001, 0,  32'h00000001, 0, 0, 1,  1});
        vecs.push_back('{OP_LESS, 0, 0, 32'h00000001, 32'hFFFFFFFF, 0,  32'h00000000, 1, 0, 1,  1});
        vecs.push_back('{OP_LESS, 1, 1, 32'h00000002, 32'h00000003, 0,  32'h00000001, 0, 0, 1,  1});
        vecs.push_back('{OP_OR,   0, 0, 32'hF0F00000, 32'h00000F0F, 0,  32'hF0F00F0F, 0, 0, 1,  1});
        vecs.push_back('{OP_OR,   0, 1, 32'h00000000, 32'hFFFFFFFF, 0,  32'h00000000, 1, 0, 1,  1});
        vecs.push_back('{OP_AND,  1, 0, 32'h0000FFFF, 32'h12345678, 0,  32'h12340000, 0, 0, 1,  1});
        vecs.push_back('{OP_ADD,  1, 0, 32'h00000000, 32'h00000000, 0,  32'hFFFFFFFF, 0, 0, 1,  1});
        vecs.push_back('{OP_ADD,  0, 0, 32'h80000000, 32'h80000000, 0,  32'h00000000, 1, 1, 1,  1});
        vecs.push_back('{OP_RSVD, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 7,  32'h00000000, 1, 0, 1,  1});
        vecs.push_back('{OP_SLL,  0, 0, 32'h00000000, 32'h00000001, 31, 32'h80000000, 0, 0, 32, 9});
        vecs.push_back('{OP_SRL,  0, 0, 32'h00000000, 32'h80000000, 31, 32'h00000001, 0, 0, 32, 9});
        vecs.push_back('{OP_SRL,  0, 0, 32'h00000000, 32'hF0000000, 4,  32'h0F000000, 0, 0, 5,  2});
        vecs.push_back('{OP_SLL,  0, 0, 32'h00000000, 32'h00000003, 5,  32'h00000060, 0, 0, 6,  3});
        vecs.push_back('{OP_SLL,  0, 0, 32'h00000000, 32'h000000A5, 0,  32'h000000A5, 0, 0, 2,  2});
`ifdef SEQ_ALU_ARITH_SHIFT_EN
        vecs.push_back('{OP_SRA,  0, 0, 32'h00000000, 32'h80000000, 3,  32'hF0000000, 0, 0, 4,  2});
`else
        vecs.push_back('{OP_SRA,  0, 0, 32'h00000000, 32'h80000000, 3,  32'h00000000, 1, 0, 1,  1});
`endif

        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0;
        invertA = 1'b0; invertB = 1'b0; src1 = '0; src2 = '0; shamt = '0;
        tick();
        tick();
        RST = 1'b0;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready",  {31'b0, in_ready},  32'd1);
        check("reset_result",    result,             32'd0);
        check("reset_zero",      {31'b0, zero},      32'd0);
        check("reset_overflow",  {31'b0, overflow},  32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].op, vecs[i].ia, vecs[i].ib, vecs[i].s1, vecs[i].s2, vecs[i].sh);
            wait_valid(lat, lat4);
            check($sformatf("v%0d_result", i),   result,                vecs[i].r);
            check($sformatf("v%0d_zero", i),     {31'b0, zero},         {31'b0, vecs[i].z});
            check($sformatf("v%0d_overflow", i), {31'b0, overflow},     {31'b0, vecs[i].v});
            check($sformatf("v%0d_latency", i),  32'(lat),              32'(vecs[i].lat));
            check($sformatf("v%0d_latency4", i), 32'(lat4),             32'(vecs[i].lat4));
            tick();
            check($sformatf("v%0d_consumed", i), {30'b0, out_valid, in_ready}, 32'd1);
            check($sformatf("v%0d_result4", i),  result4,               vecs[i].r);
            check($sformatf("v%0d_flags4", i),   {29'b0, in_ready4, zero4, overflow4},
                  {29'b0, 1'b1, vecs[i].z, vecs[i].v});
        end

        // Backpressure: result held, busy requests ignored.
        out_ready = 1'b0;
        send(OP_SRL, 1'b0, 1'b0, 32'h0, 32'hF0000000, 5'd4);
        wait_valid(lat, lat4);
        check("bp_latency", 32'(lat), 32'd5);
        op = OP_OR; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; invertA = 1'b0; invertB = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_result_c%0d", c), result, 32'h0F000000);
            check($sformatf("bp_hs_c%0d", c), {30'b0, out_valid, in_ready}, 32'd2);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_hs",     {30'b0, out_valid, in_ready}, 32'd1);
        check("bp_release_result", result, 32'h0F000000);

        // Reset while holding a result in DONE.
        out_ready = 1'b0;
        send(OP_SLL, 1'b0, 1'b0, 32'h0, 32'h00000001, 5'd2);
        wait_valid(lat, lat4);
        check("done_rst_pre_valid", {31'b0, out_valid}, 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        out_ready = 1'b1;
        check("done_rst_hs",     {30'b0, out_valid, in_ready}, 32'd1);
        check("done_rst_result", result, 32'd0);

        // Reset in the middle of a long shift: no partial result may appear afterwards.
        send(OP_SLL, 1'b0, 1'b0, 32'h0, 32'h00000001, 5'd31);
        repeat (5) tick();
        check("shift_rst_busy", {31'b0, in_ready}, 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("shift_rst_hs",     {30'b0, out_valid, in_ready}, 32'd1);
        check("shift_rst_result", result, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        check("shift_rst_no_partial", 32'(seen), 32'd0);

        send(OP_ADD, 1'b0, 1'b0, 32'd2, 32'd3, 5'd0);
        wait_valid(lat, lat4);
        check("post_rst_result",  result,   32'd5);
        check("post_rst_latency", 32'(lat), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu_shifter.md
Name: seq_alu_shifter

Overview:
- Parametrised, handshaked successor to the combinational lab ALU and shifter; a single unit performs OR/AND/ADD/LESS and logical shifts on WIDTH-bit operands.
- Shifts run iteratively at SHIFT_STEP bits per cycle, so latency depends on the operation.
- Sits between operand-issue logic and a result consumer.
- Uses valid/ready on both sides; holds its result until the consumer accepts it.

Parameters:
- WIDTH, 32, operand/result width (>=4, power of 2)
- SHIFT_STEP, 1, bits shifted per SHIFT cycle (power of 2, <= WIDTH)
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  3  000 OR, 001 AND, 010 ADD, 011 LESS, 100 SLL, 101 SRL, 110 SRA (optional), 111 reserved
- invertA  in  1  use ~src1 for OR/AND/ADD
- invertB  in  1  use ~src2 for OR/AND/ADD; ADD also adds carry-in 1
- src1  in  WIDTH  ALU operand A
- src2  in  WIDTH  ALU operand B; shift source for shifts
- shamt  in  SHAMT_W  shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- zero  out  1  result == 0
- overflow  out  1  signed overflow; ADD only, 0 for every other op

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- While RST=1 at a rising edge:
  - state <= IDLE.
  - result, zero, overflow, out_valid <= 0.
  - Any in-flight operation is discarded; no partial result is emitted.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). A request is accepted when in_valid && in_ready; all inputs are captured on that edge, and later input changes are ignored.
- IDLE, accept of OR/AND/ADD/LESS/reserved:
  - Compute combinationally from the captured inputs, register result/zero/overflow, and go to DONE.
  - out_valid rises one cycle after the accept.
- IDLE, accept of a shift:
  - Load the working register with src2 and the remaining count with shamt, then go to SHIFT.
- SHIFT, per cycle:
  - Shift by min(SHIFT_STEP, remaining) and decrement remaining by the same amount.
  - When remaining reaches 0, register result/zero and go to DONE.
  - shamt=0 passes through SHIFT for one cycle; latency accept -> out_valid = 1 + ceil(shamt/SHIFT_STEP), with a minimum of 2.
- DONE:
  - out_valid=1; result, zero and overflow are held stable while out_ready=0.
  - On out_ready=1, go to IDLE with out_valid=0.
  - No new request is accepted in the same cycle, so maximum throughput is one op per 2 cycles.
- Arithmetic rules:
  - A' = invertA ? ~src1 : src1; B' = invertB ? ~src2 : src2.
  - ADD result = A' + B' + invertB, modulo 2^WIDTH.
  - overflow = (A'[MSB]==B'[MSB]) && (result[MSB]!=A'[MSB]).
  - LESS = {0..., $signed(src1) < $signed(src2)}; the invert flags are ignored for LESS.
  - SLL fills zeros at LSB; SRL fills zeros at MSB.
  - Reserved op (111) gives result 0, zero=1, overflow=0, latency 1.
- Boundary cases:
  - shamt = WIDTH-1 is the maximum.
  - Reset asserted in SHIFT or DONE returns to IDLE next edge with out_valid=0.
  - in_valid while busy is ignored; the producer must hold the request until in_ready.

Optional Feature:
- Macro: SEQ_ALU_ARITH_SHIFT_EN.
- Defined: op 110 = SRA; each SHIFT step replicates the sign bit of the working register.
- Undefined: op 110 is treated as reserved (result 0, zero=1, latency 1); no sign-fill logic is present.

Decomposition:
- Package seq_alu_pkg holds:
  - op encodings: OP_OR, OP_AND, OP_ADD, OP_LESS, OP_SLL, OP_SRL, OP_SRA, OP_RSVD
  - FSM state typedef: IDLE/SHIFT/DONE
- One sub-module: seq_alu_core, the combinational OR/AND/ADD/LESS datapath with overflow, instantiated once in the top.
- The FSM and shift register stay in the top.

Test Plan:
- ADD, WIDTH=32: src1=0x7FFFFFFF, src2=1, invertA=0, invertB=0 -> result 0x80000000, overflow=1, zero=0, out_valid one cycle after accept.
- SUB (ADD with invertB=1): src1=5, src2=5 -> result 0, zero=1, overflow=0.
- LESS: src1=0xFFFFFFFF, src2=1 -> result 1. Swap the operands -> result 0.
- SLL, SHIFT_STEP=1: src2=0x00000001, shamt=31 -> result 0x80000000 with out_valid exactly 32 cycles after accept.
- Same op with SHIFT_STEP=4 -> out_valid after 9 cycles.
- Backpressure and reset: SRL src2=0xF0000000, shamt=4, out_ready=0 for 5 cycles.
  - Required: result 0x0F000000 held stable and in_ready=0 throughout.
  - Assert RST in the middle of a second shift -> next cycle out_valid=0, in_ready=1, result=0.
- With SEQ_ALU_ARITH_SHIFT_EN: op 110, src2=0x80000000, shamt=3 -> 0xF0000000.
- Without the macro: the same request -> result 0, zero=1.
